// File: rtl/corr_sched_pkg.sv
// rtl/corr_sched_pkg.sv - shared types and defaults for the correlation accumulator scheduler
package corr_sched_pkg;

  localparam int DATA_W_DEF = 31;
  localparam int ACC_W_DEF  = 30;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_STREAM,
    ST_WAIT,
    ST_RESULT
  } sched_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick starting at a priority pointer
module rr_arbiter #(
  parameter  int N     = 4,
  localparam int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx
);

  // Walk offsets from farthest to nearest so the requester closest to ptr wins.
  always_comb begin : p_pick
    int cand;
    cand    = 0;
    gnt     = '0;
    gnt_idx = '0;
    for (int off = N - 1; off >= 0; off--) begin
      cand = (int'(ptr) + off) % N;
      if (req[cand]) begin
        gnt     = '0;
        gnt[cand] = 1'b1;
        gnt_idx = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/corr_accum_sched.sv
// rtl/corr_accum_sched.sv - round-robin frame scheduler for the shared correlation accumulator
module corr_accum_sched
  import corr_sched_pkg::*;
#(
  parameter  int N_CH    = 4,
  parameter  int DATA_W  = DATA_W_DEF,
  parameter  int ACC_W   = ACC_W_DEF,
  parameter  int LEN_W   = 16,
  parameter  int DONE_TO = 4,
  localparam int CH_W    = $clog2(N_CH)
) (
  input  logic                     i_clk,
  input  logic                     i_resetn,
  input  logic [N_CH*DATA_W-1:0]   i_req_data,
  input  logic [N_CH-1:0]          i_req_valid,
  input  logic [N_CH-1:0]          i_req_last,
  output logic [N_CH-1:0]          o_req_ready,
  output logic [DATA_W-1:0]        o_acc_data,
  output logic                     o_acc_valid,
  output logic                     o_acc_last,
  input  logic [ACC_W-1:0]         i_acc_sum,
  input  logic                     i_acc_done,
  output logic [ACC_W-1:0]         o_res_data,
  output logic [CH_W-1:0]          o_res_ch,
  output logic [LEN_W-1:0]         o_res_len,
  output logic                     o_res_err,
  output logic                     o_res_valid,
  input  logic                     i_res_ready,
  output logic                     o_busy
);

  localparam int              TO_W    = $clog2(DONE_TO + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(DONE_TO - 1);
  localparam logic [CH_W-1:0] CH_LAST = CH_W'(N_CH - 1);

  sched_state_t state;
  sched_state_t state_next;

  logic [CH_W-1:0]   grant;
  logic [CH_W-1:0]   ptr;
  logic [LEN_W-1:0]  len;
  logic [TO_W-1:0]   wait_cnt;

  logic [DATA_W-1:0] req_data_arr [N_CH];
  logic [N_CH-1:0]   arb_gnt;
  logic [CH_W-1:0]   arb_idx;
  logic              arb_any;

  logic              sel_valid;
  logic              sel_last;
  logic [DATA_W-1:0] sel_data;

  logic              take_grant;
  logic              take_beat;
  logic              cap_done;
  logic              cap_timeout;
  logic              res_accept;

  for (genvar k = 0; k < N_CH; k++) begin : g_unpack
    assign req_data_arr[k] = i_req_data[k*DATA_W +: DATA_W];
  end

  rr_arbiter #(
    .N (N_CH)
  ) u_arb (
    .req     (i_req_valid),
    .ptr     (ptr),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx)
  );

  assign arb_any   = |arb_gnt;
  assign sel_valid = i_req_valid[grant];
  assign sel_last  = i_req_last[grant];
  assign sel_data  = req_data_arr[grant];
  assign o_busy    = (state != ST_IDLE);

  // FSM state register; reset aborts any frame in flight.
  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state, per-cycle strobes and the ready decode (only registered state feeds ready).
  always_comb begin
    state_next  = state;
    take_grant  = 1'b0;
    take_beat   = 1'b0;
    cap_done    = 1'b0;
    cap_timeout = 1'b0;
    res_accept  = 1'b0;
    o_req_ready = '0;
    case (state)
      ST_IDLE: begin
        if (arb_any) begin
          take_grant = 1'b1;
          state_next = ST_STREAM;
        end
      end
      ST_STREAM: begin
        o_req_ready[grant] = 1'b1;
        if (sel_valid) begin
          take_beat = 1'b1;
          if (sel_last) begin
            state_next = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (i_acc_done) begin
          cap_done   = 1'b1;
          state_next = ST_RESULT;
        end else if (wait_cnt == TO_LAST) begin
          cap_timeout = 1'b1;
          state_next  = ST_RESULT;
        end
      end
      ST_RESULT: begin
        if (i_res_ready) begin
          res_accept = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Registered forward path to the accumulator: one beat per accepted handshake.
  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      o_acc_data  <= '0;
      o_acc_valid <= 1'b0;
      o_acc_last  <= 1'b0;
    end else begin
      o_acc_valid <= take_beat;
      o_acc_last  <= take_beat & sel_last;
      if (take_beat) begin
        o_acc_data <= sel_data;
      end
    end
  end

  // Grant latch, saturating frame length and the done-timeout counter.
  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      grant    <= '0;
      len      <= '0;
      wait_cnt <= '0;
    end else begin
      if (take_grant) begin
        grant <= arb_idx;
        len   <= '0;
      end
      if (take_beat) begin
        if (len != '1) begin
          len <= len + 1'b1;
        end
        wait_cnt <= '0;
      end else if (state == ST_WAIT) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
    end
  end

  // Result capture, hold under backpressure, and pointer advance on acceptance.
  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      o_res_data  <= '0;
      o_res_ch    <= '0;
      o_res_len   <= '0;
      o_res_err   <= 1'b0;
      o_res_valid <= 1'b0;
      ptr         <= '0;
    end else begin
      if (cap_done || cap_timeout) begin
        o_res_data  <= cap_done ? i_acc_sum : '0;
        o_res_err   <= cap_timeout;
        o_res_ch    <= grant;
        o_res_len   <= len;
        o_res_valid <= 1'b1;
      end else if (res_accept) begin
        o_res_valid <= 1'b0;
        ptr         <= (grant == CH_LAST) ? '0 : grant + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_corr_accum_sched.sv
// tb/tb_corr_accum_sched.sv - randomized self-checking bench for corr_accum_sched
module tb_corr_accum_sched;
  import corr_sched_pkg::*;

  localparam int N_CH    = 4;
  localparam int DATA_W  = DATA_W_DEF;
  localparam int ACC_W   = ACC_W_DEF;
  localparam int LEN_W   = 16;
  localparam int DONE_TO = 4;
  localparam int CH_W    = 2;
  localparam int LEN_MAX = (1 << LEN_W) - 1;

  logic                   i_clk = 1'b0;
  logic                   i_resetn;
  logic [N_CH*DATA_W-1:0] i_req_data;
  logic [N_CH-1:0]        i_req_valid;
  logic [N_CH-1:0]        i_req_last;
  logic [N_CH-1:0]        o_req_ready;
  logic [DATA_W-1:0]      o_acc_data;
  logic                   o_acc_valid;
  logic                   o_acc_last;
  logic [ACC_W-1:0]       i_acc_sum;
  logic                   i_acc_done;
  logic [ACC_W-1:0]       o_res_data;
  logic [CH_W-1:0]        o_res_ch;
  logic [LEN_W-1:0]       o_res_len;
  logic                   o_res_err;
  logic                   o_res_valid;
  logic                   i_res_ready;
  logic                   o_busy;

  corr_accum_sched #(
    .N_CH(N_CH), .DATA_W(DATA_W), .ACC_W(ACC_W), .LEN_W(LEN_W), .DONE_TO(DONE_TO)
  ) dut (
    .i_clk(i_clk), .i_resetn(i_resetn),
    .i_req_data(i_req_data), .i_req_valid(i_req_valid), .i_req_last(i_req_last),
    .o_req_ready(o_req_ready),
    .o_acc_data(o_acc_data), .o_acc_valid(o_acc_valid), .o_acc_last(o_acc_last),
    .i_acc_sum(i_acc_sum), .i_acc_done(i_acc_done),
    .o_res_data(o_res_data), .o_res_ch(o_res_ch), .o_res_len(o_res_len),
    .o_res_err(o_res_err), .o_res_valid(o_res_valid), .i_res_ready(i_res_ready),
    .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [DATA_W-1:0] sq      [N_CH][$];
  bit                lq      [N_CH][$];
  logic [ACC_W-1:0]  exp_sum [N_CH][$];
  int                exp_len [N_CH][$];
  bit                mid     [N_CH];
  int                exp_ptr   = 0;
  bit                done_en   = 1'b1;
  bit                gaps_en   = 1'b0;
  int                ready_pct = 100;
  bit                spur      = 1'b0;
  logic [ACC_W-1:0]  acc_tot   = '0;
  logic [ACC_W-1:0]  pend_sum  = '0;
  bit                pend      = 1'b0;
  int                cyc       = 0;
  int                n_res     = 0;
  int                last_hs_cyc = 0;
  int                lat       = -1;
  bit                prev_res_valid = 1'b0;
  int                res_ch_log[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic add_frame(input int ch, input int n, input bit rnd, input logic [DATA_W-1:0] val);
    logic [ACC_W-1:0]  s;
    logic [DATA_W-1:0] v;
    s = '0;
    for (int i = 0; i < n; i++) begin
      v = rnd ? DATA_W'($urandom) : val;
      sq[ch].push_back(v);
      lq[ch].push_back(i == n - 1);
      s = s + ACC_W'(v);
    end
    exp_sum[ch].push_back(s);
    exp_len[ch].push_back(n);
  endtask

  // Expected result: next non-empty channel in round-robin order from the model pointer.
  task automatic score();
    int ch;
    int el;
    ch = -1;
    for (int o = 0; o < N_CH; o++) begin
      int c;
      c = (exp_ptr + o) % N_CH;
      if (ch < 0 && exp_sum[c].size() > 0) ch = c;
    end
    if (ch < 0) begin
      check("res_unexpected", 64'(o_res_valid), 64'd0);
    end else begin
      el = (exp_len[ch][0] > LEN_MAX) ? LEN_MAX : exp_len[ch][0];
      check("res_ch", 64'(o_res_ch), 64'(ch));
      check("res_err", 64'(o_res_err), 64'(!done_en));
      check("res_data", 64'(o_res_data), done_en ? 64'(exp_sum[ch][0]) : 64'd0);
      check("res_len", 64'(o_res_len), 64'(el));
      void'(exp_sum[ch].pop_front());
      void'(exp_len[ch].pop_front());
      exp_ptr = (ch + 1) % N_CH;
    end
    res_ch_log.push_back(int'(o_res_ch));
    n_res++;
  endtask

  task automatic drive(input logic [N_CH-1:0] hs);
    for (int k = 0; k < N_CH; k++) begin
      if (hs[k] && sq[k].size() > 0) begin
        mid[k] = !lq[k][0];
        void'(sq[k].pop_front());
        void'(lq[k].pop_front());
      end
      if (sq[k].size() == 0) begin
        mid[k] = 1'b0;
        i_req_valid[k] = 1'b0;
        i_req_last[k]  = 1'b0;
        i_req_data[k*DATA_W +: DATA_W] = '0;
      end else begin
        i_req_valid[k] = !(mid[k] && gaps_en && $urandom_range(3) == 0);
        i_req_last[k]  = lq[k][0];
        i_req_data[k*DATA_W +: DATA_W] = sq[k][0];
      end
    end
  endtask

  // One clock: sample at negedge, then update accumulator model and sources after posedge.
  task automatic step();
    logic [N_CH-1:0] hs;
    @(negedge i_clk);
    cyc++;
    hs = i_req_valid & o_req_ready;
    for (int k = 0; k < N_CH; k++)
      if (hs[k] && lq[k].size() > 0 && lq[k][0]) last_hs_cyc = cyc;
    if (o_res_valid && !prev_res_valid) lat = cyc - last_hs_cyc;
    prev_res_valid = o_res_valid;
    if (o_res_valid && i_res_ready) score();
    @(posedge i_clk);
    #1;
    i_acc_done = pend && done_en;
    i_acc_sum  = pend_sum;
    pend = 1'b0;
    if (spur) begin
      i_acc_done = 1'b1;
      i_acc_sum  = ACC_W'($urandom);
      spur = 1'b0;
    end
    if (o_acc_valid) acc_tot = acc_tot + ACC_W'(o_acc_data);
    if (o_acc_last) begin
      pend     = 1'b1;
      pend_sum = acc_tot;
      acc_tot  = '0;
    end
    drive(hs);
    i_res_ready = ($urandom_range(99) < ready_pct);
  endtask

  task automatic run_results(input string tag, input int target, input int budget);
    int start;
    start = cyc;
    while (n_res < target && cyc - start < budget) step();
    check({tag, "_count"}, 64'(n_res), 64'(target));
  endtask

  task automatic flush_model();
    for (int k = 0; k < N_CH; k++) begin
      sq[k].delete();
      lq[k].delete();
      exp_sum[k].delete();
      exp_len[k].delete();
      mid[k] = 1'b0;
    end
    pend = 1'b0;
    acc_tot = '0;
    exp_ptr = 0;
  endtask

  initial begin
    logic [63:0] snap;
    int base;

    i_resetn    = 1'b0;
    i_req_data  = '0;
    i_req_valid = '0;
    i_req_last  = '0;
    i_acc_sum   = '0;
    i_acc_done  = 1'b0;
    i_res_ready = 1'b1;
    repeat (3) @(posedge i_clk);
    #1;
    check("rst_busy", 64'(o_busy), 64'd0);
    check("rst_ready", 64'(o_req_ready), 64'd0);
    check("rst_acc", 64'({o_acc_valid, o_acc_last, o_acc_data}), 64'd0);
    check("rst_res", 64'({o_res_valid, o_res_err, o_res_ch, o_res_len, o_res_data}), 64'd0);

    // Contention: every channel holds valid from reset.
    add_frame(0, $urandom_range(12, 1), 1'b1, '0);
    add_frame(0, $urandom_range(12, 1), 1'b1, '0);
    for (int k = 1; k < N_CH; k++) add_frame(k, $urandom_range(12, 1), 1'b1, '0);
    drive('0);
    @(posedge i_clk);
    #1;
    check("rst_ready_with_valid", 64'(o_req_ready), 64'd0);
    i_resetn  = 1'b1;
    gaps_en   = 1'b1;
    ready_pct = 70;
    run_results("contention", 5, 400);
    for (int i = 0; i < 5 && i < res_ch_log.size(); i++)
      check("contention_order", 64'(res_ch_log[i]), 64'(i % N_CH));

    // Single channel, 8 samples of 5.
    gaps_en   = 1'b0;
    ready_pct = 100;
    while (o_busy) step();
    add_frame(2, 8, 1'b0, DATA_W'(5));
    run_results("single", n_res + 1, 100);
    check("single_latency", 64'(lat), 64'd3);
    check("single_sum40", 64'(o_res_data), 64'd40);

    // A done pulse outside WAIT must be ignored.
    base = n_res;
    spur = 1'b1;
    repeat (6) step();
    check("spur_res_valid", 64'(o_res_valid), 64'd0);
    check("spur_busy", 64'(o_busy), 64'd0);
    check("spur_count", 64'(n_res), 64'(base));

    // Backpressure: result held, no new frame granted.
    add_frame(0, $urandom_range(10, 2), 1'b1, '0);
    add_frame(3, $urandom_range(10, 2), 1'b1, '0);
    ready_pct = 0;
    begin
      int guard;
      guard = 0;
      while (!o_res_valid && guard < 100) begin step(); guard++; end
    end
    check("bp_reached", 64'(o_res_valid), 64'd1);
    snap = 64'({o_res_valid, o_res_err, o_res_ch, o_res_len, o_res_data});
    for (int i = 0; i < 20; i++) begin
      step();
      check("bp_hold", 64'({o_res_valid, o_res_err, o_res_ch, o_res_len, o_res_data}), snap);
      check("bp_no_ready", 64'(o_req_ready), 64'd0);
    end
    ready_pct = 100;
    run_results("bp_release", n_res + 2, 200);

    // Single-beat frame.
    add_frame(1, 1, 1'b1, '0);
    run_results("one_beat", n_res + 1, 50);
    check("one_beat_len", 64'(o_res_len), 64'd1);

    // Timeout: accumulator never answers.
    done_en = 1'b0;
    add_frame(2, 5, 1'b1, '0);
    run_results("timeout", n_res + 1, 100);
    check("timeout_latency", 64'(lat), 64'(DONE_TO + 1));
    step();
    step();
    check("timeout_idle", 64'(o_busy), 64'd0);
    done_en = 1'b1;

    // Length saturation.
    add_frame(0, 70000, 1'b0, DATA_W'(1));
    run_results("long", n_res + 1, 71000);
    check("long_len", 64'(o_res_len), 64'(LEN_MAX));
    check("long_sum", 64'(o_res_data), 64'd70000);

    // Reset in the middle of a frame.
    add_frame(2, 40, 1'b1, '0);
    repeat (10) step();
    check("midrst_busy_before", 64'(o_busy), 64'd1);
    base = n_res;
    i_resetn = 1'b0;
    #1;
    check("midrst_busy", 64'(o_busy), 64'd0);
    check("midrst_ready", 64'(o_req_ready), 64'd0);
    check("midrst_acc", 64'({o_acc_valid, o_acc_last, o_acc_data}), 64'd0);
    check("midrst_res", 64'({o_res_valid, o_res_err, o_res_ch, o_res_len, o_res_data}), 64'd0);
    flush_model();
    drive('0);
    repeat (3) step();
    i_resetn = 1'b1;
    repeat (5) step();
    check("midrst_no_result", 64'(n_res), 64'(base));
    add_frame(3, $urandom_range(6, 1), 1'b1, '0);
    add_frame(0, $urandom_range(6, 1), 1'b1, '0);
    run_results("post_rst", n_res + 2, 200);
    if (res_ch_log.size() >= 2) begin
      check("post_rst_first_ch", 64'(res_ch_log[res_ch_log.size() - 2]), 64'd0);
      check("post_rst_second_ch", 64'(res_ch_log[res_ch_log.size() - 1]), 64'd3);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/corr_accum_sched.md
# corr_accum_sched

Round-robin scheduler that shares the single correlation accumulator among N_CH correlation-product streams, one antenna pair per stream. It grants one requester a whole frame at a time and forwards that frame's samples to the accumulator with valid/last. It then captures the accumulated sum and returns it tagged with channel id, frame length and an error flag over a valid/ready result port. It sits between the per-pair complex-multiply stages and the DOA covariance assembly logic.

## Interface
Parameters:
- N_CH, 4, number of requesting streams (2..16)
- DATA_W, 31, product sample width into the accumulator
- ACC_W, 30, accumulator result width
- LEN_W, 16, frame-length counter width
- DONE_TO, 4, maximum WAIT cycles before timeout

Ports:
- i_clk  in  1  clock
- i_resetn  in  1  asynchronous, active-low reset
- i_req_data  in  N_CH*DATA_W  per-channel samples; channel k occupies bits [k*DATA_W +: DATA_W]
- i_req_valid  in  N_CH  per-channel sample valid
- i_req_last  in  N_CH  per-channel last sample of frame
- o_req_ready  out  N_CH  per-channel ready
- o_acc_data  out  DATA_W  sample to accumulator
- o_acc_valid  out  1  accumulator clock enable
- o_acc_last  out  1  last sample to accumulator
- i_acc_sum  in  ACC_W  accumulator output
- i_acc_done  in  1  accumulator result-valid pulse (accumulator self-clears the same cycle)
- o_res_data  out  ACC_W  captured sum
- o_res_ch  out  $clog2(N_CH)  channel the result belongs to
- o_res_len  out  LEN_W  number of samples in the frame
- o_res_err  out  1  WAIT timed out; o_res_data is invalid
- o_res_valid  out  1  result valid
- i_res_ready  in  1  result consumer ready
- o_busy  out  1  state != IDLE

## Operation
- FSM states: IDLE, STREAM, WAIT, RESULT.
- IDLE: if any i_req_valid bit is high, pick a grant round-robin starting at the priority pointer, latch it in grant, clear len, and go to STREAM. With no valid bits, stay in IDLE.
- STREAM: o_req_ready[grant] = 1; all other ready bits are 0. Each beat where valid and ready are both high is registered onto o_acc_data/o_acc_valid/o_acc_last, and len increments, saturating at 2^LEN_W-1. A beat with last high moves the FSM to WAIT. Non-granted channels are stalled, never dropped.
- WAIT: capture i_acc_sum on i_acc_done and go to RESULT with err=0. If DONE_TO cycles elapse after o_acc_last without done, go to RESULT with err=1 and data=0.
- RESULT: hold o_res_* stable with o_res_valid high until i_res_ready. On the handshake, set pointer = grant+1 mod N_CH and go to IDLE.
- The WAIT and IDLE states guarantee at least 2 idle accumulator cycles between frames, so the accumulator's self-clear never coincides with a new sample.
- An i_acc_done outside WAIT is ignored.
- Reset: state IDLE, pointer 0, all outputs 0.
- Reset asserted mid-frame aborts the frame; no result is produced. The upstream must restart the frame.

## Timing
- Arbitration takes 1 cycle: valid high in IDLE at cycle c gives ready at c+1.
- Accumulator path is registered: a handshake at cycle t appears on o_acc_* at t+1.
- Nominal result latency: last handshake at t, o_acc_last at t+1, i_acc_done at t+2, o_res_valid at t+3.
- Back-to-back frames: with i_res_ready held high, the next grant becomes ready at t+5 at the earliest.
- o_req_ready is a pure function of registered state; there is no combinational path from inputs to ready.
- A single-beat frame (valid with last on the first beat) is legal and gives len=1.

## Structure
- Package corr_sched_pkg: the state enum and the constants DATA_W_DEF=31 and ACC_W_DEF=30.
- Sub-module rr_arbiter: N_CH request bits plus a pointer in, one-hot grant and grant index out, combinational. It is reused for other shared resources.

## Test plan
- Single channel: ch2 sends 8 samples of value 5 with last on the 8th → one result with data=40, ch=2, len=8, err=0; o_res_valid appears 3 cycles after the last handshake.
- Contention: all 4 channels hold valid from reset → grants in order 0,1,2,3,0; every result carries the correct channel and sum.
- Backpressure: hold i_res_ready low for 20 cycles → o_res_* stable throughout; no o_req_ready asserted; the next frame begins after release.
- Timeout: the accumulator model never pulses done → after DONE_TO cycles, result with err=1, data=0, and the FSM returns to IDLE.
- Corner cases: a 1-beat frame gives len=1 and data equal to the sample. A 70000-beat frame with LEN_W=16 gives len=65535. Asserting reset mid-STREAM clears all outputs, produces no result, and leaves pointer at 0.
